dac_serializer: RTL and testbench
=================================

# dac_serializer

Output stage of the FM synthesizer: takes one mono signed PCM sample per frame from the mixer/volume stage and serializes it to the external DAC as Philips I2S, the same sample on both channels. It generates the bit clock (`s_clk`) and word select from the system clock. It raises a one-cycle sample-request pulse, which drives `interrupt_out`, each time it consumes a buffered sample. A one-entry holding register decouples the producer from the frame timing.

## Interface
- `NUM_BITS_DAC`, 24: sample width; must be ≤ `SLOT_BITS`.
- `SLOT_BITS`, 32: bit clocks per channel slot (frame = 2·`SLOT_BITS`).
- `CLK_DIV`, 4: `clk` cycles per `s_clk` half-period; ≥ 1.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `sample_in`  in  `NUM_BITS_DAC`  two's-complement sample.
- `sample_valid`  in  1  `sample_in` valid.
- `sample_ready`  out  1  holding register empty.
- `s_clk`  out  1  I2S bit clock.
- `word_select`  out  1  I2S WS; 0 = left, 1 = right.
- `serial_data`  out  1  I2S SD, MSB first.
- `interrupt_out`  out  1  one-cycle pulse: holding sample consumed, request next.
- `underrun`  out  1  sticky: a frame started with the holding register empty.

## Operation
- Divider `div_cnt` counts 0..`CLK_DIV`-1. At the terminal count, `s_clk` toggles. A 1→0 toggle is a *fall tick*.
- Frame counter `bit_cnt` counts 0..2·`SLOT_BITS`-1 and advances only on fall ticks, wrapping 2S-1 → 0 (S = `SLOT_BITS`).
- Slot position: p = `bit_cnt` mod S.
- `word_select` = 1 when `bit_cnt` ∈ [S-1, 2S-2], otherwise 0. WS therefore leads each slot by one bit (I2S delay).
- `serial_data`: for p < `NUM_BITS_DAC`, bit (`NUM_BITS_DAC`-1-p) of the frame shift register; for other p, 0.
- All outputs are registered and update only on fall ticks, except `sample_ready`, `interrupt_out` and `underrun`. The DAC samples SD and WS on the rising edge of `s_clk`.
- Holding register handshake:
  - Transfer occurs when `sample_valid` && `sample_ready`. It sets the holding register full, so `sample_ready` = 0.
  - `sample_in` is ignored while not ready.
- Frame load happens on the fall tick that wraps `bit_cnt` to 0.
  - Holding full: copy it into the frame register, mark the holding register empty, and pulse `interrupt_out` for that one `clk` cycle.
  - Holding empty: load 0 (silence), set `underrun`, and do not pulse `interrupt_out`.
  - The load decision uses the registered holding state. A transfer in the same cycle is captured into holding and is used at the next frame; that frame still counts as underrun.
- The left and right slots both send the same frame register.
- `underrun` clears only on `rst`.

## Timing
- Reset values:
  - `s_clk` = 0, `word_select` = 0, `serial_data` = 0.
  - `interrupt_out` = 0, `underrun` = 0, `sample_ready` = 1.
  - `div_cnt` = 0, `bit_cnt` = 2S-1, holding and frame registers = 0.
- After `rst` deasserts, the first `s_clk` rise is at `clk` edge `CLK_DIV`. The first fall tick is at 2·`CLK_DIV`, where `bit_cnt` wraps to 0 and the first frame loads.
- Bit period = 2·`CLK_DIV` clk. Frame = 4·`CLK_DIV`·S clk; with defaults, 512 clk per frame (≈195.3 kHz at 100 MHz).
- `interrupt_out` pulses once per frame, coincident with the frame-load fall tick. `sample_ready` rises in the same cycle.
- Sample latency: a sample accepted before load tick k appears as the MSB on SD starting at load tick k.
- Reset mid-frame: all state returns to reset values on the next edge and the pending holding sample is discarded. No partial frame continues.

## Structure
- `synth_pkg` holds the I2S constants: default `SLOT_BITS` and `CLK_DIV`, and the `FRAME_BITS` = 2·`SLOT_BITS` localparam.
- Sub-module `sclk_gen` holds the divider. It outputs `s_clk` plus one-cycle `fall_tick` and `rise_tick` strobes. `dac_serializer` holds the frame counter, holding register and shifter.
- Instantiated inside `fm_synth_top`, fed by the volume stage. `interrupt_out` is wired to the top-level interrupt.

## Test plan
- Reset release with defaults (`CLK_DIV`=4, S=32): `s_clk` first rises at cycle 4 and falls at 8; `word_select` goes high at fall tick 31 and low at fall tick 63 → WS period = 512 clk.
- Sample 24'hA5A5A5 accepted before the first load: SD carries 101001011010010110100101 then 8 zeros in the left slot, the identical pattern in the right slot, and one `interrupt_out` pulse at that load.
- Sample 24'h800000 (negative full scale): SD MSB = 1 then 23 zeros, both slots; WS transitions one bit before each MSB.
- No sample supplied before a load tick: SD is all zeros for the frame, `underrun` = 1 and stays high, no interrupt pulse; a sample accepted later plays in the next frame.
- `sample_valid` held high continuously with an incrementing counter: exactly one transfer per frame, `sample_ready` low between loads, and the consecutive values appear in order.
- `rst` asserted mid-right-slot: next cycle all outputs are at reset values; the restart timing is identical to the first test.

Source files
------------

// File: rtl/synth_pkg.sv
// rtl/synth_pkg.sv - I2S framing constants shared by the synthesizer output stage
package synth_pkg;
  localparam int DAC_BITS      = 24;
  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_CLK_DIV   = 4;
  localparam int FRAME_BITS    = 2 * I2S_SLOT_BITS;
endpackage

// File: rtl/dac_serializer_if.sv
// rtl/dac_serializer_if.sv - sample handshake plus I2S and status lines of the DAC output stage
interface dac_serializer_if
  import synth_pkg::*;
#(
  parameter int NUM_BITS_DAC = DAC_BITS
);
  logic [NUM_BITS_DAC-1:0] sample_in;
  logic                    sample_valid;
  logic                    sample_ready;
  logic                    s_clk;
  logic                    word_select;
  logic                    serial_data;
  logic                    interrupt_out;
  logic                    underrun;

  modport master (
    output sample_in, sample_valid,
    input  sample_ready, s_clk, word_select, serial_data, interrupt_out, underrun
  );

  modport slave (
    input  sample_in, sample_valid,
    output sample_ready, s_clk, word_select, serial_data, interrupt_out, underrun
  );
endinterface

// File: rtl/sclk_gen.sv
// rtl/sclk_gen.sv - divides clk down to the I2S bit clock and flags each of its edges
module sclk_gen
  import synth_pkg::*;
#(
  parameter int CLK_DIV = I2S_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic s_clk,
  output logic fall_tick,
  output logic rise_tick
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          s_clk_q, s_clk_d;
  logic          terminal;

  always_comb begin
    terminal  = (div_cnt_q == DW'(CLK_DIV - 1));
    div_cnt_d = terminal ? '0 : div_cnt_q + 1'b1;
    s_clk_d   = terminal ? ~s_clk_q : s_clk_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      s_clk_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      s_clk_q   <= s_clk_d;
    end
  end

  // Strobes mark the clk cycle whose closing edge moves s_clk.
  assign s_clk     = s_clk_q;
  assign fall_tick = terminal & s_clk_q;
  assign rise_tick = terminal & ~s_clk_q;
endmodule

// File: rtl/dac_serializer.sv
// rtl/dac_serializer.sv - buffers one mono PCM sample per frame and shifts it out as Philips I2S on both channels
module dac_serializer
  import synth_pkg::*;
#(
  parameter int NUM_BITS_DAC = DAC_BITS,
  parameter int SLOT_BITS    = I2S_SLOT_BITS,
  parameter int CLK_DIV      = I2S_CLK_DIV
) (
  input logic             clk,
  input logic             rst,
  dac_serializer_if.slave bus
);
  localparam int FRAME_LEN = 2 * SLOT_BITS;
  localparam int CW        = $clog2(FRAME_LEN);
  localparam int IW        = (NUM_BITS_DAC > 1) ? $clog2(NUM_BITS_DAC) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_LEN - 1);

  logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [NUM_BITS_DAC-1:0] hold_q, hold_d;
  logic [NUM_BITS_DAC-1:0] frame_q, frame_d;
  logic                    hold_full_q, hold_full_d;
  logic                    ws_q, ws_d;
  logic                    sd_q, sd_d;
  logic                    irq_q, irq_d;
  logic                    underrun_q, underrun_d;
  logic                    s_clk, fall_tick, rise_tick_unused;
  logic                    xfer, frame_load;
  logic [CW-1:0]           pos;
  logic [IW-1:0]           idx;

  sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk       (clk),
    .rst       (rst),
    .s_clk     (s_clk),
    .fall_tick (fall_tick),
    .rise_tick (rise_tick_unused)
  );

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    frame_d     = frame_q;
    ws_d        = ws_q;
    sd_d        = sd_q;
    irq_d       = 1'b0;
    underrun_d  = underrun_q;
    pos         = '0;
    idx         = '0;
    xfer        = bus.sample_valid && !hold_full_q;
    frame_load  = fall_tick && (bit_cnt_q == LAST_BIT);

    if (fall_tick) begin
      bit_cnt_d = frame_load ? '0 : bit_cnt_q + 1'b1;
      // The load decision sees only the registered holding state, so a
      // same-cycle transfer waits for the following frame.
      if (frame_load) begin
        if (hold_full_q) begin
          frame_d     = hold_q;
          hold_full_d = 1'b0;
          irq_d       = 1'b1;
        end else begin
          frame_d    = '0;
          underrun_d = 1'b1;
        end
      end
      ws_d = (bit_cnt_d >= CW'(SLOT_BITS - 1)) && (bit_cnt_d <= CW'(FRAME_LEN - 2));
      pos  = (bit_cnt_d >= CW'(SLOT_BITS)) ? bit_cnt_d - CW'(SLOT_BITS) : bit_cnt_d;
      if (pos < CW'(NUM_BITS_DAC)) begin
        idx  = IW'(NUM_BITS_DAC - 1) - IW'(pos);
        sd_d = frame_d[idx];
      end else begin
        sd_d = 1'b0;
      end
    end

    if (xfer) begin
      hold_d      = bus.sample_in;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q   <= LAST_BIT;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      frame_q     <= '0;
      ws_q        <= 1'b0;
      sd_q        <= 1'b0;
      irq_q       <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      frame_q     <= frame_d;
      ws_q        <= ws_d;
      sd_q        <= sd_d;
      irq_q       <= irq_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.sample_ready  = ~hold_full_q;
  assign bus.s_clk         = s_clk;
  assign bus.word_select   = ws_q;
  assign bus.serial_data   = sd_q;
  assign bus.interrupt_out = irq_q;
  assign bus.underrun      = underrun_q;
endmodule

// File: tb/tb_dac_serializer.sv
// tb/tb_dac_serializer.sv - scoreboard bench for the I2S DAC serializer
module tb_dac_serializer;
  localparam int N          = 24;
  localparam int S          = 32;
  localparam int DIV        = 4;
  localparam int FIRST_LOAD = 2 * DIV;
  localparam int FRAME_CLK  = 4 * DIV * S;

  bit clk = 1'b0;
  bit rst = 1'b1;
  always #5 clk = ~clk;

  dac_serializer_if #(.NUM_BITS_DAC(N)) bus ();

  dac_serializer #(.NUM_BITS_DAC(N), .SLOT_BITS(S), .CLK_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  int           cyc    = 0;
  bit           rst_q  = 1'b1;
  bit           m_full = 1'b0;
  logic [N-1:0] m_hold = '0;
  bit           m_ur   = 1'b0;
  bit           m_irq  = 1'b0;
  bit           mon_on = 1'b0;
  logic [S-1:0] exp_q[$];

  // Reference model: edge count since reset, holding register and frame loads.
  always @(posedge clk) begin : model
    bit load_now;
    bit xfer_now;
    rst_q <= rst;
    if (rst) begin
      cyc    <= 0;
      m_full <= 1'b0;
      m_hold <= '0;
      m_ur   <= 1'b0;
      m_irq  <= 1'b0;
    end else begin
      load_now = ((cyc + 1) >= FIRST_LOAD) && ((((cyc + 1) - FIRST_LOAD) % FRAME_CLK) == 0);
      xfer_now = (bus.sample_valid === 1'b1) && !m_full;
      cyc   <= cyc + 1;
      m_irq <= load_now && m_full;
      if (load_now) begin
        if (!m_full) m_ur <= 1'b1;
        exp_q.push_back(m_full ? {m_hold, {(S-N){1'b0}}} : '0);
        exp_q.push_back(m_full ? {m_hold, {(S-N){1'b0}}} : '0);
      end
      if (xfer_now) begin
        m_hold <= bus.sample_in;
        m_full <= 1'b1;
      end else if (load_now) begin
        m_full <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin : monitor
    bit exp_s;
    if (mon_on) begin
      exp_s = ((cyc / DIV) % 2) == 1;
      checks++;
      if (bus.s_clk !== exp_s) begin
        errors++;
        $display("FAIL mon_sclk cyc=%0d got=%b exp=%b", cyc, bus.s_clk, exp_s);
      end
      checks++;
      if (bus.interrupt_out !== m_irq) begin
        errors++;
        $display("FAIL mon_irq cyc=%0d got=%b exp=%b", cyc, bus.interrupt_out, m_irq);
      end
      checks++;
      if (bus.underrun !== m_ur) begin
        errors++;
        $display("FAIL mon_underrun cyc=%0d got=%b exp=%b", cyc, bus.underrun, m_ur);
      end
      checks++;
      if (bus.sample_ready !== !m_full) begin
        errors++;
        $display("FAIL mon_ready cyc=%0d got=%b exp=%b", cyc, bus.sample_ready, !m_full);
      end
    end
  end

  int           rises  = 0;
  bit           prev_s = 1'b0;
  logic [S-1:0] slot_w = '0;

  // DAC-side decoder: samples WS/SD at each s_clk rise and pops expected slots.
  always @(negedge clk) begin : decoder
    int           k;
    bit           ws_exp;
    logic [S-1:0] w;
    logic [S-1:0] e;
    if (rst_q) begin
      rises  <= 0;
      prev_s <= 1'b0;
      slot_w <= '0;
      exp_q.delete();
    end else begin
      prev_s <= bus.s_clk;
      if (bus.s_clk === 1'b1 && !prev_s) begin
        k      = (rises == 0) ? 2*S - 1 : (rises - 1) % (2*S);
        ws_exp = (k >= S - 1) && (k <= 2*S - 2);
        checks++;
        if (bus.word_select !== ws_exp) begin
          errors++;
          $display("FAIL dec_ws cyc=%0d bit=%0d got=%b exp=%b", cyc, k, bus.word_select, ws_exp);
        end
        if (rises > 0) begin
          w = {slot_w[S-2:0], bus.serial_data};
          slot_w <= w;
          if ((k % S) == S - 1) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL dec_slot cyc=%0d got=%h exp=none", cyc, w);
            end else begin
              e = exp_q.pop_front();
              if (w !== e) begin
                errors++;
                $display("FAIL dec_slot cyc=%0d got=%h exp=%h", cyc, w, e);
              end
            end
          end
        end
        rises <= rises + 1;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    checks += 6;
    if (bus.s_clk !== 1'b0)         begin errors++; $display("FAIL %s s_clk got=%b exp=0", tag, bus.s_clk); end
    if (bus.word_select !== 1'b0)   begin errors++; $display("FAIL %s ws got=%b exp=0", tag, bus.word_select); end
    if (bus.serial_data !== 1'b0)   begin errors++; $display("FAIL %s sd got=%b exp=0", tag, bus.serial_data); end
    if (bus.interrupt_out !== 1'b0) begin errors++; $display("FAIL %s irq got=%b exp=0", tag, bus.interrupt_out); end
    if (bus.underrun !== 1'b0)      begin errors++; $display("FAIL %s underrun got=%b exp=0", tag, bus.underrun); end
    if (bus.sample_ready !== 1'b1)  begin errors++; $display("FAIL %s ready got=%b exp=1", tag, bus.sample_ready); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    mon_on = 1'b1;
    rst    = 1'b0;
  endtask

  task automatic test_startup_a5();
    int rise_at = -1, fall_at = -1, ws_rise = -1, ws_fall = -1, irqs = 0, irq_cyc = -1;
    bit ps = 1'b0, pw = 1'b0;
    bus.sample_in    = 24'hA5A5A5;
    bus.sample_valid = 1'b1;
    while (cyc < 530) begin
      @(negedge clk);
      if (bus.sample_ready === 1'b0) bus.sample_valid = 1'b0;
      if (bus.s_clk === 1'b1 && !ps && rise_at < 0) rise_at = cyc;
      if (bus.s_clk === 1'b0 && ps && fall_at < 0) fall_at = cyc;
      if (bus.word_select === 1'b1 && !pw && ws_rise < 0) ws_rise = cyc;
      if (bus.word_select === 1'b0 && pw && ws_fall < 0) ws_fall = cyc;
      if (bus.interrupt_out === 1'b1) begin irqs++; irq_cyc = cyc; end
      if (cyc == 519) begin
        checks++;
        if (bus.underrun !== 1'b0) begin errors++; $display("FAIL startup_ur_before got=%b exp=0", bus.underrun); end
      end
      ps = bus.s_clk;
      pw = bus.word_select;
    end
    checks += 7;
    if (rise_at != 4)   begin errors++; $display("FAIL startup_rise got=%0d exp=4", rise_at); end
    if (fall_at != 8)   begin errors++; $display("FAIL startup_fall got=%0d exp=8", fall_at); end
    if (ws_rise != 256) begin errors++; $display("FAIL startup_ws_rise got=%0d exp=256", ws_rise); end
    if (ws_fall != 512) begin errors++; $display("FAIL startup_ws_fall got=%0d exp=512", ws_fall); end
    if (irqs != 1)      begin errors++; $display("FAIL startup_irqs got=%0d exp=1", irqs); end
    if (irq_cyc != 8)   begin errors++; $display("FAIL startup_irq_cyc got=%0d exp=8", irq_cyc); end
    if (bus.underrun !== 1'b1) begin errors++; $display("FAIL startup_ur_after got=%b exp=1", bus.underrun); end
  endtask

  task automatic test_underrun_then_negative();
    int ws_r1 = -1, ws_r2 = -1, ws_f = -1, irqs = 0, irq_cyc = -1, ur_drop = 0;
    logic sd_load = 1'bx;
    bit pw;
    while (cyc < 600) @(negedge clk);
    pw = bus.word_select;
    bus.sample_in    = 24'h800000;
    bus.sample_valid = 1'b1;
    while (cyc < 1560) begin
      @(negedge clk);
      if (bus.sample_ready === 1'b0) bus.sample_valid = 1'b0;
      if (bus.word_select === 1'b1 && !pw) begin
        if (ws_r1 < 0) ws_r1 = cyc; else if (ws_r2 < 0) ws_r2 = cyc;
      end
      if (bus.word_select === 1'b0 && pw && ws_f < 0) ws_f = cyc;
      if (cyc == 1032) sd_load = bus.serial_data;
      if (bus.interrupt_out === 1'b1) begin irqs++; irq_cyc = cyc; end
      if (bus.underrun !== 1'b1) ur_drop++;
      pw = bus.word_select;
    end
    checks += 7;
    if (ws_r1 != 768)         begin errors++; $display("FAIL neg_ws_rise got=%0d exp=768", ws_r1); end
    if (ws_r2 - ws_r1 != 512) begin errors++; $display("FAIL neg_ws_period got=%0d exp=512", ws_r2 - ws_r1); end
    if (ws_f != 1024)         begin errors++; $display("FAIL neg_ws_fall got=%0d exp=1024", ws_f); end
    if (sd_load !== 1'b1)     begin errors++; $display("FAIL neg_msb got=%b exp=1", sd_load); end
    if (irqs != 1)            begin errors++; $display("FAIL neg_irqs got=%0d exp=1", irqs); end
    if (irq_cyc != 1032)      begin errors++; $display("FAIL neg_irq_cyc got=%0d exp=1032", irq_cyc); end
    if (ur_drop != 0)         begin errors++; $display("FAIL neg_ur_sticky got=%0d exp=0", ur_drop); end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] cnt = 24'h000100;
    int xc[5];
    int xfers = 0;
    bit r;
    rst = 1'b1;
    bus.sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus.sample_in    = cnt;
    bus.sample_valid = 1'b1;
    while (cyc < 1546) begin
      r = bus.sample_ready;
      @(negedge clk);
      if (r) begin
        if (xfers < 5) xc[xfers] = cyc;
        xfers++;
        cnt++;
        bus.sample_in = cnt;
      end
    end
    checks += 6;
    if (xfers != 5)          begin errors++; $display("FAIL b2b_xfers got=%0d exp=5", xfers); end
    if (xc[0] != 1)          begin errors++; $display("FAIL b2b_first got=%0d exp=1", xc[0]); end
    if (xc[2] != 521)        begin errors++; $display("FAIL b2b_third got=%0d exp=521", xc[2]); end
    if (xc[3] - xc[2] != 512) begin errors++; $display("FAIL b2b_spacing got=%0d exp=512", xc[3] - xc[2]); end
    if (xc[4] != 1545)       begin errors++; $display("FAIL b2b_fifth got=%0d exp=1545", xc[4]); end
    if (bus.underrun !== 1'b0) begin errors++; $display("FAIL b2b_underrun got=%b exp=0", bus.underrun); end
  endtask

  task automatic test_reset_mid();
    int rise_at = -1, fall_at = -1, irqs = 0, irq_cyc = -1;
    bit ps = 1'b0;
    while (cyc < 1866) @(negedge clk);
    checks++;
    if (bus.word_select !== 1'b1) begin errors++; $display("FAIL mid_ws_right got=%b exp=1", bus.word_select); end
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_reset");
    bus.sample_valid = 1'b0;
    rst = 1'b0;
    while (cyc < 1040) begin
      @(negedge clk);
      if (cyc == 7) begin
        bus.sample_in    = 24'h123456;
        bus.sample_valid = 1'b1;
      end
      if (cyc == 8) begin
        checks += 3;
        if (bus.sample_ready !== 1'b0)  begin errors++; $display("FAIL same_cycle_ready got=%b exp=0", bus.sample_ready); end
        if (bus.underrun !== 1'b1)      begin errors++; $display("FAIL same_cycle_ur got=%b exp=1", bus.underrun); end
        if (bus.interrupt_out !== 1'b0) begin errors++; $display("FAIL same_cycle_irq got=%b exp=0", bus.interrupt_out); end
        bus.sample_valid = 1'b0;
      end
      if (bus.s_clk === 1'b1 && !ps && rise_at < 0) rise_at = cyc;
      if (bus.s_clk === 1'b0 && ps && fall_at < 0) fall_at = cyc;
      if (bus.interrupt_out === 1'b1) begin irqs++; irq_cyc = cyc; end
      ps = bus.s_clk;
    end
    checks += 4;
    if (rise_at != 4)   begin errors++; $display("FAIL restart_rise got=%0d exp=4", rise_at); end
    if (fall_at != 8)   begin errors++; $display("FAIL restart_fall got=%0d exp=8", fall_at); end
    if (irqs != 1)      begin errors++; $display("FAIL restart_irqs got=%0d exp=1", irqs); end
    if (irq_cyc != 520) begin errors++; $display("FAIL restart_irq_cyc got=%0d exp=520", irq_cyc); end
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    test_reset();
    test_startup_a5();
    test_underrun_then_negative();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
